button_conditioner: RTL and testbench

- Conditions the four raw paddle buttons before the vga block consumes them.
- Per button: 2-flop synchroniser, then a counter-based debouncer.
- Per side: up+down conflict resolution, then an auto-repeat state machine.
- Outputs are a clean level and a single-cycle step pulse per direction. The block sits between the board pins and vga in the pixel-clock domain (25.125 MHz).

---
 rtl/button_conditioner.sv | 159 +++++++++++++++
 tb/tb_button_conditioner.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Brief    : Synchronise, debounce, conflict-resolve and auto-repeat the four
//            raw paddle buttons feeding the vga block (pixel-clock domain).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
    parameter int ACTIVE_HIGH     = 1,
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int REPEAT_DELAY    = 7537500,
    parameter int REPEAT_PERIOD   = 1256250
) (
    input  logic clk,
    input  logic rst,
    input  logic left_up,
    input  logic left_down,
    input  logic right_up,
    input  logic right_down,
    output logic left_up_level,
    output logic left_down_level,
    output logic right_up_level,
    output logic right_down_level,
    output logic left_up_step,
    output logic left_down_step,
    output logic right_up_step,
    output logic right_down_step
);

    localparam int c_db_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_rpt_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rpt_w  = (c_rpt_max > 1) ? $clog2(c_rpt_max) : 1;

    localparam logic [c_db_w-1:0]  c_db_last    = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_db_w-1:0]  c_db_one     = c_db_w'(1);
    localparam logic [c_rpt_w-1:0] c_delay_last = c_rpt_w'(REPEAT_DELAY - 1);
    localparam logic [c_rpt_w-1:0] c_period_last = c_rpt_w'(REPEAT_PERIOD - 1);
    localparam logic [c_rpt_w-1:0] c_rpt_one    = c_rpt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Channel order: 0 = left_up, 1 = left_down, 2 = right_up, 3 = right_down.
    // Channels 2k/2k+1 form a side; partner of channel i is i^1.
    logic [3:0] w_raw;
    logic [3:0] w_db;
    logic [3:0] w_step;

    assign w_raw = {right_down, right_up, left_down, left_up};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_chan
            localparam int c_pair = gi ^ 1;

            logic              r_meta;
            logic              r_sync2;
            logic              r_sync;
            logic              r_db;
            logic [c_db_w-1:0] r_db_cnt;
            state_t            r_state;
            logic [c_rpt_w-1:0] r_rcnt;
            logic              r_step;
            logic              w_eff;

            // Third stage holds the polarity-normalised sample so pressed=1 downstream.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_meta  <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_sync  <= 1'b0;
                end else begin
                    r_meta  <= w_raw[gi];
                    r_sync2 <= r_meta;
                    r_sync  <= (ACTIVE_HIGH != 0) ? r_sync2 : ~r_sync2;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_db     <= 1'b0;
                    r_db_cnt <= '0;
                end else if (r_sync != r_db) begin
                    if (r_db_cnt == c_db_last) begin
                        r_db     <= r_sync;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_db_one;
                    end
                end else begin
                    r_db_cnt <= '0;
                end
            end

            assign w_db[gi] = r_db;
            assign w_eff    = w_db[gi] & ~w_db[c_pair];

            // A falling eff always wins over a pulse due on the same edge.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= ST_IDLE;
                    r_rcnt  <= '0;
                    r_step  <= 1'b0;
                end else begin
                    r_step <= 1'b0;
                    case (r_state)
                        ST_IDLE: begin
                            if (w_eff) begin
                                r_step  <= 1'b1;
                                r_rcnt  <= '0;
                                r_state <= ST_DELAY;
                            end
                        end
                        ST_DELAY: begin
                            if (!w_eff) begin
                                r_state <= ST_IDLE;
                            end else if (r_rcnt == c_delay_last) begin
                                r_step  <= 1'b1;
                                r_rcnt  <= '0;
                                r_state <= ST_REPEAT;
                            end else begin
                                r_rcnt <= r_rcnt + c_rpt_one;
                            end
                        end
                        ST_REPEAT: begin
                            if (!w_eff) begin
                                r_state <= ST_IDLE;
                            end else if (r_rcnt == c_period_last) begin
                                r_step <= 1'b1;
                                r_rcnt <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + c_rpt_one;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end

            assign w_step[gi] = r_step;
        end
    endgenerate

    assign left_up_level    = w_db[0];
    assign left_down_level  = w_db[1];
    assign right_up_level   = w_db[2];
    assign right_down_level = w_db[3];
    assign left_up_step     = w_step[0];
    assign left_down_step   = w_step[1];
    assign right_up_step    = w_step[2];
    assign right_down_step  = w_step[3];

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Directed bench for button_conditioner, both pin polarities.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic lu, ld, ru, rd;
    logic plu, pld, pru, prd;
    // Vectors ordered {left_up, left_down, right_up, right_down}
    logic [3:0] a_lvl, a_stp, b_lvl, b_stp;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .ACTIVE_HIGH(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) u_dut_a (
        .clk(clk), .rst(rst),
        .left_up(lu), .left_down(ld), .right_up(ru), .right_down(rd),
        .left_up_level(a_lvl[3]), .left_down_level(a_lvl[2]),
        .right_up_level(a_lvl[1]), .right_down_level(a_lvl[0]),
        .left_up_step(a_stp[3]), .left_down_step(a_stp[2]),
        .right_up_step(a_stp[1]), .right_down_step(a_stp[0])
    );

    button_conditioner #(
        .ACTIVE_HIGH(0), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .left_up(plu), .left_down(pld), .right_up(pru), .right_down(prd),
        .left_up_level(b_lvl[3]), .left_down_level(b_lvl[2]),
        .right_up_level(b_lvl[1]), .right_down_level(b_lvl[0]),
        .left_up_step(b_stp[3]), .left_down_step(b_stp[2]),
        .right_up_step(b_stp[1]), .right_down_step(b_stp[0])
    );

    // One active edge, then settle to the falling edge for sampling/driving.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        lu = 0; ld = 0; ru = 0; rd = 0;
        plu = 1; pld = 1; pru = 1; prd = 1;
        for (int k = 0; k < 14; k++) begin
            rst = (k < 3);
            tick();
            vectors++; if (a_lvl !== 4'b0) begin miscompares++; $display("FAIL reset a_lvl k=%0d got %b want %b", k, a_lvl, 4'b0); end
            vectors++; if (a_stp !== 4'b0) begin miscompares++; $display("FAIL reset a_stp k=%0d got %b want %b", k, a_stp, 4'b0); end
            vectors++; if (b_lvl !== 4'b0) begin miscompares++; $display("FAIL reset b_lvl k=%0d got %b want %b", k, b_lvl, 4'b0); end
            vectors++; if (b_stp !== 4'b0) begin miscompares++; $display("FAIL reset b_stp k=%0d got %b want %b", k, b_stp, 4'b0); end
        end
    endtask

    task automatic test_press;
        logic [3:0] e_lvl, e_stp;
        for (int k = 0; k < 56; k++) begin
            lu = (k < 40);
            tick();
            e_lvl = {(k >= 6 && k <= 45), 3'b000};
            e_stp = {(k == 7 || k == 17 || k == 22 || k == 27 || k == 32 || k == 37 || k == 42), 3'b000};
            vectors++; if (a_lvl !== e_lvl) begin miscompares++; $display("FAIL press a_lvl k=%0d got %b want %b", k, a_lvl, e_lvl); end
            vectors++; if (a_stp !== e_stp) begin miscompares++; $display("FAIL press a_stp k=%0d got %b want %b", k, a_stp, e_stp); end
            vectors++; if ((b_lvl | b_stp) !== 4'b0) begin miscompares++; $display("FAIL press b_out k=%0d got %b/%b want 0", k, b_lvl, b_stp); end
        end
    endtask

    task automatic test_release_repress;
        logic [3:0] e_lvl, e_stp;
        for (int k = 0; k < 56; k++) begin
            lu = (k < 12) || (k >= 30 && k < 40);
            tick();
            e_lvl = {((k >= 6 && k <= 17) || (k >= 36 && k <= 45)), 3'b000};
            e_stp = {(k == 7 || k == 17 || k == 37), 3'b000};
            vectors++; if (a_lvl !== e_lvl) begin miscompares++; $display("FAIL release a_lvl k=%0d got %b want %b", k, a_lvl, e_lvl); end
            vectors++; if (a_stp !== e_stp) begin miscompares++; $display("FAIL release a_stp k=%0d got %b want %b", k, a_stp, e_stp); end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] e_lvl, e_stp;
        for (int k = 0; k < 46; k++) begin
            rd = (k <= 2) || (k >= 5 && k <= 7) || (k >= 10 && k < 30);
            tick();
            e_lvl = {3'b000, (k >= 16 && k <= 35)};
            e_stp = {3'b000, (k == 17 || k == 27 || k == 32)};
            vectors++; if (a_lvl !== e_lvl) begin miscompares++; $display("FAIL bounce a_lvl k=%0d got %b want %b", k, a_lvl, e_lvl); end
            vectors++; if (a_stp !== e_stp) begin miscompares++; $display("FAIL bounce a_stp k=%0d got %b want %b", k, a_stp, e_stp); end
        end
    endtask

    task automatic test_conflict;
        logic [3:0] e_lvl, e_stp;
        for (int k = 0; k < 56; k++) begin
            lu = (k < 41);
            ld = (k >= 10 && k < 30);
            tick();
            e_lvl = {(k >= 6 && k <= 46), (k >= 16 && k <= 35), 2'b00};
            e_stp = {(k == 7 || k == 37 || k == 47), 3'b000};
            vectors++; if (a_lvl !== e_lvl) begin miscompares++; $display("FAIL conflict a_lvl k=%0d got %b want %b", k, a_lvl, e_lvl); end
            vectors++; if (a_stp !== e_stp) begin miscompares++; $display("FAIL conflict a_stp k=%0d got %b want %b", k, a_stp, e_stp); end
        end
    endtask

    task automatic test_reset_mid_repeat;
        logic [3:0] e_lvl, e_stp;
        for (int k = 0; k < 56; k++) begin
            ru  = (k < 40);
            rst = (k == 24);
            tick();
            e_lvl = {2'b00, ((k >= 6 && k <= 23) || (k >= 31 && k <= 45)), 1'b0};
            e_stp = {2'b00, (k == 7 || k == 17 || k == 22 || k == 32 || k == 42), 1'b0};
            vectors++; if (a_lvl !== e_lvl) begin miscompares++; $display("FAIL rst_mid a_lvl k=%0d got %b want %b", k, a_lvl, e_lvl); end
            vectors++; if (a_stp !== e_stp) begin miscompares++; $display("FAIL rst_mid a_stp k=%0d got %b want %b", k, a_stp, e_stp); end
            vectors++; if ((b_lvl | b_stp) !== 4'b0) begin miscompares++; $display("FAIL rst_mid b_out k=%0d got %b/%b want 0", k, b_lvl, b_stp); end
        end
        rst = 1'b0;
    endtask

    task automatic test_polarity;
        logic [3:0] e_lvl, e_stp;
        for (int k = 0; k < 36; k++) begin
            pld = (k >= 20);
            tick();
            e_lvl = {1'b0, (k >= 6 && k <= 25), 2'b00};
            e_stp = {1'b0, (k == 7 || k == 17 || k == 22), 2'b00};
            vectors++; if (b_lvl !== e_lvl) begin miscompares++; $display("FAIL polarity b_lvl k=%0d got %b want %b", k, b_lvl, e_lvl); end
            vectors++; if (b_stp !== e_stp) begin miscompares++; $display("FAIL polarity b_stp k=%0d got %b want %b", k, b_stp, e_stp); end
            vectors++; if ((a_lvl | a_stp) !== 4'b0) begin miscompares++; $display("FAIL polarity a_out k=%0d got %b/%b want 0", k, a_lvl, a_stp); end
        end
    endtask

    initial begin
        rst = 1'b1;
        lu = 0; ld = 0; ru = 0; rd = 0;
        plu = 1; pld = 1; pru = 1; prd = 1;
        @(negedge clk);
        test_reset();
        test_press();
        test_release_repress();
        test_bounce();
        test_conflict();
        test_reset_mid_repeat();
        test_polarity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
